// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, FSM encoding and sizing helpers for keypad entry
package keypad_pkg;

  localparam logic [5:0] KEY_A    = 6'h0A;
  localparam logic [5:0] KEY_STAR = 6'h0E;
  localparam logic [5:0] KEY_HASH = 6'h0F;
  localparam logic [5:0] KEY_NONE = 6'h1F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUSH    = 2'd2
  } entry_state_e;

  // 10**n; used to size the binary result for a given digit count
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// rtl/keypad_fifo.sv - synchronous first-word-fall-through FIFO for committed values
module keypad_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             do_rd;
  logic             do_wr;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd    = rd_en && !empty;
  // a write into a full FIFO is legal when the head leaves on the same edge
  assign do_wr    = wr_en && (!full || do_rd);
  assign rd_valid = !empty;
  // head is masked so rd_data reads 0 whenever nothing is queued
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // pointer update; the extra MSB distinguishes full from empty and wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // storage array carries no reset; stale words are hidden by the empty mask
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - decimal keystroke entry, BCD-to-binary conversion and result queue
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  key_pulse,
  input  logic [5:0]            key_code,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [3:0]            entry_cnt,
  output logic                  busy,
  output logic                  drop,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_en
);

  localparam int         BCD_W    = 4 * DIGITS;
  localparam int         REQ_W    = $clog2(pow10(DIGITS));
  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  if (DIGITS < 1 || DIGITS > 15) begin : g_bad_digits
    $error("keypad_entry: DIGITS must be in 1..15");
  end
  if (WIDTH < REQ_W) begin : g_bad_width
    $error("keypad_entry: WIDTH too small to hold DIGITS decimal digits");
  end

  entry_state_e     state_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic [BCD_W-1:0] sr_q;
  logic [3:0]       dcnt_q;
  logic [WIDTH-1:0] acc_q;
  logic             drop_q;

  logic             is_digit;
  logic [BCD_W-1:0] digit_d;
  logic [5:0]       align_d;
  logic [WIDTH-1:0] acc_d;
  logic             fifo_full;
  logic             push_d;

  assign is_digit = (key_code <= 6'd9);
  assign digit_d  = BCD_W'(key_code[3:0]);
  // left-justify the entry so the most significant digit sits in the top nibble
  assign align_d  = {DIGITS_C - cnt_q, 2'b00};
  // acc * 10 + next digit, built from shifts
  assign acc_d    = (acc_q << 3) + (acc_q << 1) + WIDTH'(sr_q[BCD_W-1 -: 4]);
  // PUSH may proceed when there is room or the head is popped on this edge
  assign push_d   = (state_q == ST_PUSH) && (!fifo_full || rd_en);

  assign entry_bcd = bcd_q;
  assign entry_cnt = cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign drop      = drop_q;

  // entry register, conversion FSM and drop strobe
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      dcnt_q  <= '0;
      acc_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_pulse) begin
            if (is_digit) begin
              if (cnt_q < DIGITS_C) begin
                bcd_q <= (bcd_q << 4) | digit_d;
                cnt_q <= cnt_q + 4'd1;
              end else begin
                drop_q <= 1'b1;
              end
            end else if (key_code == KEY_STAR) begin
              if (cnt_q != 4'd0) begin
                bcd_q <= bcd_q >> 4;
                cnt_q <= cnt_q - 4'd1;
              end
            end else if (key_code == KEY_A) begin
              bcd_q <= '0;
              cnt_q <= '0;
            end else if (key_code == KEY_HASH) begin
              if (cnt_q != 4'd0) begin
                sr_q    <= bcd_q << align_d;
                dcnt_q  <= cnt_q;
                bcd_q   <= '0;
                cnt_q   <= '0;
                acc_q   <= '0;
                state_q <= ST_CONVERT;
              end
            end
          end
        end
        ST_CONVERT: begin
          drop_q <= key_pulse;
          acc_q  <= acc_d;
          sr_q   <= sr_q << 4;
          dcnt_q <= dcnt_q - 4'd1;
          if (dcnt_q == 4'd1) state_q <= ST_PUSH;
        end
        ST_PUSH: begin
          drop_q <= key_pulse;
          if (push_d) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  keypad_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst      (rst),
    .wr_en    (push_d),
    .wr_data  (acc_q),
    .full     (fifo_full),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized and directed bench for keypad_entry against a behavioural model
module tb_keypad_entry;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;

  logic              sys_clk;
  logic              rst;
  logic              key_pulse;
  logic [5:0]        key_code;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [3:0]        entry_cnt;
  logic              busy;
  logic              drop;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_en;

  keypad_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .key_code  (key_code),
    .entry_bcd (entry_bcd),
    .entry_cnt (entry_cnt),
    .busy      (busy),
    .drop      (drop),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_en     (rd_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // model: typed digits in entry order, queued results, and a busy phase
  int              dq[$];
  longint unsigned fq[$];
  int              mode;       // 0 idle, 1 converting, 2 waiting to push
  int              conv_left;
  longint unsigned pend;
  bit              exp_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    fq.delete();
    mode = 0;
    conv_left = 0;
    pend = 0;
    exp_drop = 0;
  endtask

  task automatic model_edge(input bit p, input int c, input bit r);
    bit pop;
    bit can;
    int om;
    om = mode;
    exp_drop = 0;
    pop = r && (fq.size() > 0);
    can = (fq.size() < DEPTH) || pop;
    if (p && om != 0) exp_drop = 1;
    if (p && om == 0) begin
      if (c <= 9) begin
        if (dq.size() < DIGITS) dq.push_back(c);
        else exp_drop = 1;
      end else if (c == 14) begin
        if (dq.size() > 0) void'(dq.pop_back());
      end else if (c == 10) begin
        dq.delete();
      end else if (c == 15 && dq.size() > 0) begin
        pend = 0;
        foreach (dq[i]) pend = pend * 10 + longint'(dq[i]);
        conv_left = dq.size();
        dq.delete();
        mode = 1;
      end
    end
    if (pop) void'(fq.pop_front());
    if (om == 1) begin
      conv_left--;
      if (conv_left == 0) mode = 2;
    end else if (om == 2 && can) begin
      fq.push_back(pend);
      mode = 0;
    end
  endtask

  task automatic check_all();
    logic [63:0] v;
    v = 0;
    foreach (dq[i]) v = (v << 4) | 64'(dq[i]);
    check("entry_bcd", 64'(entry_bcd), v);
    check("entry_cnt", 64'(entry_cnt), 64'(dq.size()));
    check("busy", 64'(busy), 64'(mode != 0));
    check("drop", 64'(drop), 64'(exp_drop));
    check("rd_valid", 64'(rd_valid), 64'(fq.size() > 0));
    check("rd_data", 64'(rd_data), (fq.size() > 0) ? fq[0] : 64'd0);
  endtask

  // one clock: inputs set at the falling edge, model advanced at the rising edge
  task automatic step(input bit p, input int c, input bit r);
    key_pulse = p;
    key_code  = 6'(c);
    rd_en     = r;
    @(posedge sys_clk);
    model_edge(p, c, r);
    @(negedge sys_clk);
    key_pulse = 1'b0;
    key_code  = 6'h1F;
    rd_en     = 1'b0;
    check_all();
  endtask

  task automatic key(input int c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h1F, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (rd_valid && guard < 20) begin
      step(1'b0, 6'h1F, 1'b1);
      guard++;
    end
    check("drain_bound", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    int n;
    int guard;
    int r;
    rst = 1'b1;
    key_pulse = 1'b0;
    key_code = 6'h1F;
    rd_en = 1'b0;
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_all();
    rst = 1'b0;
    idle(1);

    // 1,2,3,# : busy for four cycles then 123 at the head
    key(1); key(2); key(3); key(15);
    n = 1;
    guard = 0;
    while (busy && guard < 40) begin
      idle(1);
      if (busy) n++;
      guard++;
    end
    check("busy_len", 64'(n), 64'd4);
    check("val_123", 64'(rd_data), 64'd123);
    drain();

    // backspace mid-entry, then * and A on an empty entry
    key(4); key(5); key(14); key(6); key(15);
    idle(6);
    check("val_46", 64'(rd_data), 64'd46);
    drain();
    key(14); key(10);
    check("empty_nodrop", 64'(drop), 64'd0);

    // ninth digit rejected
    key(9); key(8); key(7); key(6); key(5); key(4); key(3); key(2);
    key(1);
    check("ovf_drop", 64'(drop), 64'd1);
    check("ovf_bcd", 64'(entry_bcd), 64'h98765432);
    key(15);
    idle(10);
    check("val_big", 64'(rd_data), 64'd98765432);
    drain();

    // fill the FIFO and stall in PUSH
    for (int d = 1; d <= 4; d++) begin
      key(d); key(15); idle(3);
    end
    key(5); key(15);
    idle(4);
    check("stall_busy", 64'(busy), 64'd1);
    key(7);
    check("stall_drop", 64'(drop), 64'd1);
    step(1'b0, 6'h1F, 1'b1);
    check("stall_release", 64'(busy), 64'd0);
    check("head_2", 64'(rd_data), 64'd2);
    drain();

    // A discards, # on empty ignored, unused codes ignored
    key(7); key(10); key(15); key(11); key(12); key(13); key(31); key(6'h25);
    idle(2);
    check("nothing_pushed", 64'(rd_valid), 64'd0);

    // asynchronous reset in the middle of a conversion
    key(9); key(9); key(15); idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(entry_cnt), 64'd0);
    check("rst_bcd", 64'(entry_bcd), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    model_reset();
    @(negedge sys_clk);
    rst = 1'b0;
    key(3); key(15);
    idle(3);
    check("val_3", 64'(rd_data), 64'd3);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      step(1'b1, $urandom_range(0, 9), $urandom_range(0, 5) == 0);
      else if (r < 48) step(1'b1, 15, $urandom_range(0, 5) == 0);
      else if (r < 53) step(1'b1, 14, 1'b0);
      else if (r < 55) step(1'b1, 10, 1'b0);
      else if (r < 60) step(1'b1, $urandom_range(11, 63), 1'b0);
      else             step(1'b0, $urandom_range(0, 63), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
